// File: rtl/csb_fifo_flopram_ctrl.sv
// ---------------------------------------------------------------------------
// csb_fifo_flopram_ctrl
//
// Pointer and flow-control sequencer for the small write-delayed flopram on
// the falcon2csb side of the CSB master. The ram captures push data into an
// input register one cycle (iwe) and commits it to an entry the next cycle
// (we/wa). This block hands out write slots, schedules the delayed commit,
// gates the ram clock to commit cycles and exposes a valid/ready pop stream
// whose data is the ram dout at ram_ra.
//
// Ports
//   clk         in   core clock, all flops on posedge
//   reset_      in   asynchronous active-low reset
//   wr_req      in   push request (push data is on ram di this cycle)
//   wr_ready    out  push accepted when wr_req & wr_ready
//   rd_pvld     out  pop data valid on ram dout
//   rd_prdy     in   pop consumer ready
//   ram_iwe     out  ram input-capture enable (di -> di_d)
//   ram_we      out  ram commit enable (di_d -> entry ram_wa)
//   ram_wa      out  ram commit address
//   ram_ra      out  ram read address
//   ram_clk_en  out  enable for the ram clock gate
//   wr_count    out  slots reserved (pushed, not yet popped)
//   idle        out  no entries held and no commit pending
// ---------------------------------------------------------------------------
module csb_fifo_flopram_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          wr_req,
    output logic          wr_ready,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic          ram_iwe,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [AW-1:0] ram_ra,
    output logic          ram_clk_en,
    output logic [CW-1:0] wr_count,
    output logic          idle
);

    // Write side: wr_count counts reserved slots, so it moves on the push
    // cycle and is what guards against overflow.
    logic [AW-1:0] wr_adr_q, wr_adr_d;
    logic [CW-1:0] wr_count_q, wr_count_d;

    // Read side: rd_count only counts entries whose commit edge has passed,
    // so a slot is never presented for pop while it is still in di_d.
    logic [AW-1:0] rd_adr_q, rd_adr_d;
    logic [CW-1:0] rd_count_q, rd_count_d;

    // Delayed commit stage.
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_wa_q, ram_wa_d;

    logic          wr_pushing;
    logic          rd_popping;

    // wr_ready depends on registered state only; a same-cycle pop does not
    // open a slot until the following cycle.
    assign wr_ready   = (wr_count_q != CW'(DEPTH));
    assign wr_pushing = wr_req & wr_ready;
    assign ram_iwe    = wr_pushing;

    assign rd_pvld    = (rd_count_q != '0);
    assign rd_popping = rd_pvld & rd_prdy;
    assign ram_ra     = rd_adr_q;

    assign ram_we     = ram_we_q;
    assign ram_wa     = ram_wa_q;
    assign ram_clk_en = ram_we_q;

    assign wr_count   = wr_count_q;
    assign idle       = (wr_count_q == '0) & ~ram_we_q;

    always_comb begin
        wr_adr_d   = wr_adr_q;
        rd_adr_d   = rd_adr_q;
        ram_we_d   = wr_pushing;
        ram_wa_d   = ram_wa_q;
        // DEPTH is a power of two, so the natural AW-bit wrap is mod DEPTH.
        if (wr_pushing) begin
            ram_wa_d = wr_adr_q;
            wr_adr_d = wr_adr_q + AW'(1);
        end
        if (rd_popping) begin
            rd_adr_d = rd_adr_q + AW'(1);
        end
        wr_count_d = wr_count_q + CW'(wr_pushing) - CW'(rd_popping);
        rd_count_d = rd_count_q + CW'(ram_we_q)   - CW'(rd_popping);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_adr_q   <= '0;
            rd_adr_q   <= '0;
            wr_count_q <= '0;
            rd_count_q <= '0;
            ram_we_q   <= 1'b0;
            ram_wa_q   <= '0;
        end else begin
            wr_adr_q   <= wr_adr_d;
            rd_adr_q   <= rd_adr_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
            ram_we_q   <= ram_we_d;
            ram_wa_q   <= ram_wa_d;
        end
    end

    // The only gap between reserved and committed is the one commit in
    // flight, and neither count can leave [0, DEPTH].
    always_ff @(posedge clk) begin
        if (reset_) begin
            assert (wr_count_q <= CW'(DEPTH));
            assert (rd_count_q <= wr_count_q);
            assert ((wr_count_q - rd_count_q) == CW'(ram_we_q));
        end
    end

endmodule

// File: tb/tb_csb_fifo_flopram_ctrl.sv
module tb_csb_fifo_flopram_ctrl;
    localparam int D  = 4;
    localparam int AW = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset_ = 1'b0;
    logic          wr_req = 1'b0;
    logic          rd_prdy = 1'b0;
    logic          wr_ready, rd_pvld, ram_iwe, ram_we, ram_clk_en, idle;
    logic [AW-1:0] ram_wa, ram_ra;
    logic [CW-1:0] wr_count;

    csb_fifo_flopram_ctrl #(.DEPTH(D), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset_(reset_), .wr_req(wr_req), .wr_ready(wr_ready),
        .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .ram_iwe(ram_iwe), .ram_we(ram_we),
        .ram_wa(ram_wa), .ram_ra(ram_ra), .ram_clk_en(ram_clk_en),
        .wr_count(wr_count), .idle(idle)
    );

    always #5 clk = ~clk;

    // Behavioural write-delayed flopram driven by the DUT controls.
    logic [49:0] di = '0;
    logic [49:0] di_d;
    logic [49:0] mem [D];
    logic [49:0] dout;
    assign dout = mem[ram_ra];
    always @(posedge clk) begin
        if (ram_iwe) di_d <= di;
        if (ram_we)  mem[ram_wa] <= di_d;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: occupancy counts plus an in-order scoreboard.
    int          m_res;      // reserved slots
    int          m_com;      // committed, unpopped entries
    int          m_pend;     // commit in flight
    int          m_push_n;   // accepted pushes since reset
    int          m_pop_n;    // pops since reset
    logic [49:0] sb [$];

    function automatic void model_reset();
        m_res = 0; m_com = 0; m_pend = 0; m_push_n = 0; m_pop_n = 0;
        sb.delete();
    endfunction

    task automatic set_in(input bit req, input bit prdy);
        wr_req  = req;
        rd_prdy = prdy;
        di      = {18'($urandom), 32'($urandom)};
        #1;
    endtask

    // Advance one clock and move the model by the rules of the push/pop streams.
    task automatic adv();
        bit push, pop;
        push = wr_req && (m_res < D);
        pop  = (m_com > 0) && rd_prdy;
        @(posedge clk);
        m_com  = m_com + m_pend - int'(pop);
        m_res  = m_res + int'(push) - int'(pop);
        m_pend = int'(push);
        if (pop)  begin void'(sb.pop_front()); m_pop_n++; end
        if (push) begin sb.push_back(di); m_push_n++; end
        @(negedge clk);
    endtask

    task automatic do_reset();
        wr_req = 1'b0; rd_prdy = 1'b0;
        reset_ = 1'b0;
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        wr_req = 1'b0; rd_prdy = 1'b0; reset_ = 1'b0;
        repeat (3) @(negedge clk);
        reset_ = 1'b1;
        model_reset();
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        checks++; if (rd_pvld !== 1'b0) begin errors++; $display("FAIL reset_rd_pvld got=%b exp=0", rd_pvld); end
        checks++; if (wr_count !== 3'd0) begin errors++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", idle); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
        checks++; if (ram_clk_en !== 1'b0 || ram_iwe !== 1'b0 || ram_wa !== 2'd0 || ram_ra !== 2'd0)
            begin errors++; $display("FAIL reset_ram_ctl got clk_en=%b iwe=%b wa=%0d ra=%0d exp 0 0 0 0", ram_clk_en, ram_iwe, ram_wa, ram_ra); end
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        set_in(1, 1);
        checks++; if (ram_iwe !== 1'b1) begin errors++; $display("FAIL single_c0_iwe got=%b exp=1", ram_iwe); end
        adv();
        set_in(0, 1);
        checks++; if (ram_we !== 1'b1 || ram_wa !== 2'd0 || ram_clk_en !== 1'b1 || rd_pvld !== 1'b0)
            begin errors++; $display("FAIL single_c1 got we=%b wa=%0d clk_en=%b pvld=%b exp 1 0 1 0", ram_we, ram_wa, ram_clk_en, rd_pvld); end
        adv();
        set_in(0, 1);
        checks++; if (rd_pvld !== 1'b1 || ram_ra !== 2'd0) begin errors++; $display("FAIL single_c2 got pvld=%b ra=%0d exp 1 0", rd_pvld, ram_ra); end
        checks++; if (dout !== sb[0]) begin errors++; $display("FAIL single_data got=%h exp=%h", dout, sb[0]); end
        adv();
        set_in(0, 0);
        checks++; if (wr_count !== 3'd0 || idle !== 1'b1 || rd_pvld !== 1'b0)
            begin errors++; $display("FAIL single_c3 got cnt=%0d idle=%b pvld=%b exp 0 1 0", wr_count, idle, rd_pvld); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0);
            checks++; if (ram_iwe !== (i < 4)) begin errors++; $display("FAIL fill_iwe c%0d got=%b exp=%b", i, ram_iwe, (i < 4)); end
            checks++; if (wr_ready !== (i < 4)) begin errors++; $display("FAIL fill_wr_ready c%0d got=%b exp=%b", i, wr_ready, (i < 4)); end
            checks++; if (rd_pvld !== (i >= 2)) begin errors++; $display("FAIL fill_pvld c%0d got=%b exp=%b", i, rd_pvld, (i >= 2)); end
            if (i >= 1) begin
                checks++; if (ram_we !== 1'b1 || ram_wa !== AW'(i - 1))
                    begin errors++; $display("FAIL fill_commit c%0d got we=%b wa=%0d exp 1 %0d", i, ram_we, ram_wa, i - 1); end
            end
            adv();
        end
        set_in(0, 0);
        checks++; if (wr_count !== 3'd4 || wr_ready !== 1'b0) begin errors++; $display("FAIL fill_full got cnt=%0d rdy=%b exp 4 0", wr_count, wr_ready); end
    endtask

    // Continues from the full state left by test_fill.
    task automatic test_full_pop();
        set_in(1, 1);
        checks++; if (wr_ready !== 1'b0 || ram_iwe !== 1'b0 || rd_pvld !== 1'b1)
            begin errors++; $display("FAIL fullpop_c0 got rdy=%b iwe=%b pvld=%b exp 0 0 1", wr_ready, ram_iwe, rd_pvld); end
        checks++; if (dout !== sb[0]) begin errors++; $display("FAIL fullpop_data got=%h exp=%h", dout, sb[0]); end
        adv();
        set_in(1, 0);
        checks++; if (wr_ready !== 1'b1 || ram_iwe !== 1'b1) begin errors++; $display("FAIL fullpop_c1 got rdy=%b iwe=%b exp 1 1", wr_ready, ram_iwe); end
        adv();
        set_in(0, 0);
        checks++; if (ram_we !== 1'b1 || ram_wa !== 2'd0 || wr_count !== 3'd4 || wr_ready !== 1'b0)
            begin errors++; $display("FAIL fullpop_c2 got we=%b wa=%0d cnt=%0d rdy=%b exp 1 0 4 0", ram_we, ram_wa, wr_count, wr_ready); end
        adv();
    endtask

    task automatic test_wrap();
        do_reset();
        set_in(1, 0); adv();
        set_in(1, 0); adv();
        for (int i = 0; i < 10; i++) begin
            set_in(1, 1);
            checks++; if (wr_count !== 3'd2 || rd_pvld !== 1'b1)
                begin errors++; $display("FAIL wrap_cnt c%0d got cnt=%0d pvld=%b exp 2 1", i, wr_count, rd_pvld); end
            checks++; if (ram_ra !== AW'(m_pop_n % D) || ram_wa !== AW'((m_push_n - 1) % D))
                begin errors++; $display("FAIL wrap_adr c%0d got ra=%0d wa=%0d exp %0d %0d", i, ram_ra, ram_wa, m_pop_n % D, (m_push_n - 1) % D); end
            checks++; if (dout !== sb[0]) begin errors++; $display("FAIL wrap_data c%0d got=%h exp=%h", i, dout, sb[0]); end
            adv();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin set_in(1, 0); adv(); end
        wr_req = 1'b0; #1;
        checks++; if (wr_count !== 3'd3 || ram_we !== 1'b1) begin errors++; $display("FAIL arst_setup got cnt=%0d we=%b exp 3 1", wr_count, ram_we); end
        reset_ = 1'b0;
        #1;
        checks++; if (wr_count !== 3'd0 || ram_we !== 1'b0 || rd_pvld !== 1'b0 || wr_ready !== 1'b1 || idle !== 1'b1 || ram_ra !== 2'd0 || ram_clk_en !== 1'b0)
            begin errors++; $display("FAIL arst_immediate got cnt=%0d we=%b pvld=%b rdy=%b idle=%b ra=%0d exp 0 0 0 1 1 0", wr_count, ram_we, rd_pvld, wr_ready, idle, ram_ra); end
        model_reset();
        @(posedge clk); @(negedge clk);
        reset_ = 1'b1;
        set_in(1, 0); adv();
        set_in(0, 0);
        checks++; if (ram_we !== 1'b1 || ram_wa !== 2'd0) begin errors++; $display("FAIL arst_first_push got we=%b wa=%0d exp 1 0", ram_we, ram_wa); end
        adv();
    endtask

    task automatic test_random();
        bit exp_rdy, exp_pvld, pop;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom % 4) != 0, ($urandom % 3) != 0);
            exp_rdy  = (m_res < D);
            exp_pvld = (m_com > 0);
            pop      = exp_pvld && rd_prdy;
            checks++; if (wr_ready !== exp_rdy) begin errors++; $display("FAIL rnd_wr_ready c%0d got=%b exp=%b", i, wr_ready, exp_rdy); end
            checks++; if (rd_pvld !== exp_pvld) begin errors++; $display("FAIL rnd_rd_pvld c%0d got=%b exp=%b", i, rd_pvld, exp_pvld); end
            checks++; if (ram_iwe !== (wr_req && exp_rdy)) begin errors++; $display("FAIL rnd_iwe c%0d got=%b exp=%b", i, ram_iwe, wr_req && exp_rdy); end
            checks++; if (ram_we !== (m_pend != 0) || ram_clk_en !== (m_pend != 0))
                begin errors++; $display("FAIL rnd_we c%0d got we=%b clk_en=%b exp=%0d", i, ram_we, ram_clk_en, m_pend); end
            checks++; if (wr_count !== CW'(m_res)) begin errors++; $display("FAIL rnd_wr_count c%0d got=%0d exp=%0d", i, wr_count, m_res); end
            checks++; if (idle !== (m_res == 0 && m_pend == 0)) begin errors++; $display("FAIL rnd_idle c%0d got=%b exp=%b", i, idle, (m_res == 0 && m_pend == 0)); end
            checks++; if (ram_ra !== AW'(m_pop_n % D)) begin errors++; $display("FAIL rnd_ra c%0d got=%0d exp=%0d", i, ram_ra, m_pop_n % D); end
            if (m_pend != 0) begin
                checks++; if (ram_wa !== AW'((m_push_n - 1) % D)) begin errors++; $display("FAIL rnd_wa c%0d got=%0d exp=%0d", i, ram_wa, (m_push_n - 1) % D); end
            end
            if (pop) begin
                checks++; if (dout !== sb[0]) begin errors++; $display("FAIL rnd_data c%0d got=%h exp=%h", i, dout, sb[0]); end
            end
            adv();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_fill();
        test_full_pop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
